// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchroniser, 16x-style oversampled frame recovery, framing-error/break handling.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote around each sample point instead of a single sample.
`timescale 1ns/1ps
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state_q;
  logic                 rx_meta_q, rxs_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q, data_out_q;
  logic                 data_valid_q, frame_error_q, busy_q;
  logic                 at_sample;
  logic                 sample_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  always_comb begin
    at_sample = 1'b0;
    case (state_q)
      START:      at_sample = (tick_cnt_q == MID_CNT);
      DATA, STOP: at_sample = (tick_cnt_q == LAST_CNT);
      default:    at_sample = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  // The two earlier votes live in hist_q; the third is the live rxs at the sample point.
  logic [1:0] hist_q;
  logic [2:0] votes;
  logic [TW-1:0] first_cnt;

  assign votes      = {hist_q, rxs_q};
  assign sample_bit = (votes[2] & votes[1]) | (votes[2] & votes[0]) | (votes[1] & votes[0]);
  assign first_cnt  = (state_q == START) ? MID_CNT - TW'(2) : LAST_CNT - TW'(2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (state_q == IDLE || state_q == BREAK) begin
      hist_q <= '0;
    end else if (sample_tick) begin
      if (at_sample)
        hist_q <= '0;
      else if (tick_cnt_q >= first_cnt)
        hist_q <= {hist_q[0], rxs_q};
    end
  end
`else
  assign sample_bit = rxs_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      if (sample_tick) begin
        case (state_q)
          IDLE: if (!rxs_q) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
          START: if (at_sample) begin
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            if (sample_bit) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
          DATA: if (at_sample) begin
            shreg_q    <= {sample_bit, shreg_q[DATA_BITS-1:1]};
            tick_cnt_q <= '0;
            if (bit_idx_q == LAST_BIT)
              state_q <= STOP;
            else
              bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
          STOP: if (at_sample) begin
            tick_cnt_q <= '0;
            if (sample_bit) begin
              data_out_q   <= shreg_q;
              data_valid_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= BREAK;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
          // A held-low line must return high before another start edge is accepted.
          BREAK: if (rxs_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomised scoreboard bench for uart_rx_deserializer: frames are queued as expected events
// and a negedge monitor pops and checks them whenever the DUT pulses data_valid or frame_error.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int FRAME_LAT = 8 + (DB + 1) * OS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic          rx_in;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_error;
  logic          busy;

  typedef struct {
    bit            err;
    logic [DB-1:0] data;
    int            tick;
  } exp_t;

  exp_t          exp_q[$];
  int            tests  = 0;
  int            errors = 0;
  int            tick_no = 0;
  int            div = 0;
  logic [DB-1:0] last_good = '0;
  bit            prev_pulse = 1'b0;

  uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % TICK_DIV;
      sample_tick = (div == 0);
    end
  end

  always @(posedge clk) if (sample_tick) tick_no <= tick_no + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (tick %0d)", name, act, req, tick_no);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!sample_tick) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_ok);
    exp_t e;
    e.err  = !stop_ok;
    e.data = stop_ok ? b : last_good;
    e.tick = tick_no + FRAME_LAT;
    exp_q.push_back(e);
    if (stop_ok) last_good = b;
    $display("[TB] send 0x%02h stop=%0d expect %s at tick %0d", b, stop_ok,
             stop_ok ? "valid" : "frame_error", e.tick);
    drive(1'b0, OS);
    for (int i = 0; i < DB; i++) drive(b[i], OS);
    drive(stop_ok, OS);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_pulse = 1'b0;
      end else begin
        if (data_valid || frame_error) begin
          chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, data_valid, frame_error}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] got %s data_out=0x%02h at tick %0d", frame_error ? "frame_error" : "valid",
                     data_out, tick_no);
            chk("kind_frame_error", {31'd0, frame_error}, {31'd0, e.err});
            chk("kind_data_valid", {31'd0, data_valid}, {31'd0, !e.err});
            chk("data_out", {24'd0, data_out}, {24'd0, e.data});
            chk("pulse_tick", tick_no, e.tick);
            chk("busy_at_pulse", {31'd0, busy}, {31'd0, e.err});
          end
        end
        prev_pulse = data_valid || frame_error;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] b;
    logic [DB-1:0] g_exp;
    bit            err;
    exp_t          e;
    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", {24'd0, data_out}, 32'd0);
    chk("reset_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_error}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5);

    // Single good frame
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 5);

    // Short low glitch is rejected at mid start bit
    drive(1'b0, 4);
    drive(1'b1, 4);
    chk("glitch_busy_before_mid", {31'd0, busy}, 32'd1);
    drive(1'b1, 1);
    chk("glitch_busy_after_mid", {31'd0, busy}, 32'd0);
    drive(1'b1, 5);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0);
    drive(1'b0, 40);
    chk("break_busy_low", {31'd0, busy}, 32'd1);
    chk("break_data_kept", {24'd0, data_out}, 32'hA5);
    drive(1'b1, 1);
    chk("break_busy_release", {31'd0, busy}, 32'd0);
    drive(1'b1, 5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive(1'b1, 5);

    // Reset in the middle of data bit 3 of 0x5A
    b = 8'h5A;
    drive(1'b0, OS);
    for (int i = 0; i < 3; i++) drive(b[i], OS);
    drive(b[3], OS / 2);
    rst = 1'b0;
    #1;
    chk("midreset_data_out", {24'd0, data_out}, 32'd0);
    chk("midreset_valid", {31'd0, data_valid}, 32'd0);
    chk("midreset_ferr", {31'd0, frame_error}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    last_good = '0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 5);

    // One-tick low glitch exactly on the sample point of data bit 2 of 0xFF
`ifdef UART_RX_MAJORITY_EN
    g_exp = 8'hFF;
`else
    g_exp = 8'hFB;
`endif
    e.err = 1'b0;
    e.data = g_exp;
    e.tick = tick_no + FRAME_LAT;
    exp_q.push_back(e);
    last_good = g_exp;
    $display("[TB] send 0xFF with sample-point glitch on bit 2, expect 0x%02h", g_exp);
    drive(1'b0, OS);
    for (int i = 0; i < DB; i++) begin
      if (i == 2) begin
        drive(1'b1, OS / 2);
        drive(1'b0, 1);
        drive(1'b1, OS / 2 - 1);
      end else begin
        drive(1'b1, OS);
      end
    end
    drive(1'b1, OS);
    drive(1'b1, 3);

    // Randomised frames with occasional framing errors and random idle gaps
    for (int n = 0; n < 20; n++) begin
      b   = DB'($urandom_range(0, (1 << DB) - 1));
      err = ($urandom_range(0, 9) == 0);
      send_frame(b, !err);
      if (err) begin
        drive(1'b0, $urandom_range(0, 30));
        drive(1'b1, $urandom_range(1, 12));
      end else begin
        drive(1'b1, $urandom_range(0, 12));
      end
    end

    drive(1'b1, 200);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
